// File: rtl/present80_encrypt_ctrl_pkg.sv
// PRESENT-80 shared widths, S-box table and engine FSM state type.
package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int ROUNDS  = 31;
    localparam int CNT_W   = 5;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } fsm_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present80_encrypt_ctrl_if.sv
// Host-side start/done bus of the PRESENT-80 engine.
interface present80_encrypt_ctrl_if import present_pkg::*; ();

    logic               start;
    logic [BLOCK_W-1:0] plaintext;
    logic [KEY_W-1:0]   key;
    logic               busy;
    logic               ready;
    logic               done;
    logic [BLOCK_W-1:0] ciphertext;

    modport master (
        output start, plaintext, key,
        input  busy, ready, done, ciphertext
    );

    modport slave (
        input  start, plaintext, key,
        output busy, ready, done, ciphertext
    );

endinterface

// File: rtl/present80_encrypt_ctrl_key_update.sv
// PRESENT-80 key schedule step: rotate, S-box top nibble, inject counter.
module present80_key_update import present_pkg::*; (
    input  logic [KEY_W-1:0] key_in,
    input  logic [CNT_W-1:0] rc,
    output logic [KEY_W-1:0] key_out
);

    logic [KEY_W-1:0] rot;

    // Left rotation by 61 is a right rotation by 19.
    assign rot = {key_in[18:0], key_in[79:19]};

    assign key_out = {
        sbox4(rot[79:76]),
        rot[75:20],
        rot[19:15] ^ rc,
        rot[14:0]
    };

endmodule

// File: rtl/present80_encrypt_ctrl_player.sv
// PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays.
module present80_player import present_pkg::*; (
    input  logic [BLOCK_W-1:0] state_in,
    output logic [BLOCK_W-1:0] state_out
);

    for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
        localparam int P = (i == 63) ? 63 : (i * 16) % 63;
        assign state_out[P] = state_in[i];
    end

endmodule

// File: rtl/present80_encrypt_ctrl.sv
// Iterative PRESENT-80 encryption engine, one round per clock.
module present80_encrypt_ctrl import present_pkg::*; (
    input logic clk,
    input logic reset,
    present80_encrypt_ctrl_if.slave bus
);

    fsm_e               fsm_q;
    fsm_e               fsm_d;
    logic [CNT_W-1:0]   rc_q;
    logic [BLOCK_W-1:0] state_q;
    logic [BLOCK_W-1:0] ct_q;
    logic [KEY_W-1:0]   key_q;
    logic [KEY_W-1:0]   key_nx;
    logic [BLOCK_W-1:0] mix;
    logic [BLOCK_W-1:0] sl;
    logic [BLOCK_W-1:0] pl;
    logic               done_q;
    logic               last;

    assign mix  = state_q ^ key_q[79:16];
    assign last = (rc_q == CNT_W'(ROUNDS));

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sl[4*n +: 4] = sbox4(mix[4*n +: 4]);
    end

    present80_player u_player (
        .state_in  (sl),
        .state_out (pl)
    );

    present80_key_update u_key (
        .key_in  (key_q),
        .rc      (rc_q),
        .key_out (key_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (bus.start) fsm_d = ROUND;
            ROUND:   if (last) fsm_d = FINAL;
            FINAL:   fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (fsm_q != IDLE);
        bus.ready = (fsm_q == IDLE);
    end

    // Counter saturates at the last round so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= bus.plaintext;
                        key_q   <= bus.key;
                        rc_q    <= CNT_W'(1);
                    end
                end
                ROUND: begin
                    state_q <= pl;
                    key_q   <= key_nx;
                    if (!last) rc_q <= rc_q + CNT_W'(1);
                end
                FINAL: begin
                    ct_q   <= mix;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_present80_encrypt_ctrl.sv
// Scoreboard bench for the PRESENT-80 engine with a loop-level cipher model.
module tb_present80_encrypt_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    present80_encrypt_ctrl_if bus ();

    present80_encrypt_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [63:0] exp_q [$];
    int acc_q [$];
    int done_cycs [$];
    logic [63:0] ct_hold = '0;

    logic [3:0] sb_t [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] m_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[(i == 63) ? 63 : (i * 16) % 63] = x[i];
        return y;
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb_t[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt,
                                              input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        logic [4:0] r5;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = m_perm(m_sub(s ^ k[79:16]));
            k = {k[18:0], k[79:19]};
            k[79:76] = sb_t[k[79:76]];
            r5 = 5'(r);
            k[19:15] = k[19:15] ^ r5;
        end
        return s ^ k[79:16];
    endfunction

    function automatic logic [79:0] rnd80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: pops expected results on done, checks hold and handshake.
    always @(negedge clk) begin
        logic [63:0] e;
        int a;
        logic exp_busy;
        if (reset) begin
            ct_hold = '0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got %h want none",
                             bus.ciphertext);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("ciphertext", 80'(bus.ciphertext), 80'(e));
                    check("latency", 80'(cyc - a), 80'(32));
                    ct_hold = e;
                end
            end else begin
                check("ct_hold", 80'(bus.ciphertext), 80'(ct_hold));
            end
            exp_busy = (exp_q.size() != 0);
            check("busy", 80'(bus.busy), 80'(exp_busy));
            check("ready", 80'(bus.ready), 80'(!exp_busy));
        end
    end

    task automatic issue(input logic [63:0] pt, input logic [79:0] k,
                         input logic [63:0] e, input bit keep);
        int n;
        n = 0;
        while (!bus.ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.ready) begin
            fail_now("issue_wait_ready");
            return;
        end
        bus.start = 1'b1;
        bus.plaintext = pt;
        bus.key = k;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        bus.plaintext = rnd64();
        bus.key = rnd80();
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bc;
        int d0;
        int n;
        logic [63:0] pt;
        logic [79:0] k;

        bus.start = 1'b0;
        bus.plaintext = '0;
        bus.key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 80'(bus.busy), 80'(0));
        check("rst_ready", 80'(bus.ready), 80'(1));
        check("rst_done", 80'(bus.done), 80'(0));
        check("rst_ct", 80'(bus.ciphertext), 80'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) bc++;
        end
        check("busy_cycles", 80'(bc), 80'(32));
        drain();

        issue(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0);
        drain();

        // Start held high: second block accepted in the done cycle.
        issue({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b1);
        bus.plaintext = {64{1'b1}};
        bus.key = {80{1'b1}};
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) fail_now("wait_first_done");
        issue({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
        drain();
        if (done_cycs.size() >= 2)
            check("done_spacing",
                  80'(done_cycs[$] - done_cycs[$-1]), 80'(33));
        else
            fail_now("done_spacing");

        // Starts while busy are ignored.
        d0 = done_cnt;
        issue(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.plaintext = rnd64();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.plaintext = rnd64();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        #1;
        check("single_done", 80'(done_cnt - d0), 80'(1));

        // Asynchronous reset mid-block.
        pt = rnd64();
        k = rnd80();
        issue(pt, k, m_encrypt(pt, k), 1'b0);
        repeat (17) @(posedge clk);
        #3;
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("abort_busy", 80'(bus.busy), 80'(0));
        check("abort_ready", 80'(bus.ready), 80'(1));
        check("abort_done", 80'(bus.done), 80'(0));
        check("abort_ct", 80'(bus.ciphertext), 80'(0));
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 80'(done_cnt - d0), 80'(0));
        issue(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
        drain();

        for (int i = 0; i < 6; i++) begin
            pt = rnd64();
            k = rnd80();
            issue(pt, k, m_encrypt(pt, k), 1'b0);
        end
        drain();

        d0 = done_cnt;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_done", 80'(done_cnt - d0), 80'(0));
        check("idle_ready", 80'(bus.ready), 80'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/present80_encrypt_ctrl.md
Name: present80_encrypt_ctrl

Overview:
Iterative PRESENT-80 encryption engine controller. It sequences the existing combinational PLayer permutation together with a 16-nibble S-box layer and the 80-bit key schedule, one round per clock, over 31 rounds plus a final key whitening. It provides a start/done handshake to the host-side crypto wrapper and is the block that owns and drives the PLayer datapath.

Parameters:
- ROUNDS, 31, number of full rounds; fixed at 31 for PRESENT-80 compliance and must not be overridden.
- CNT_W, 5, width of the round counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request to encrypt; sampled only in IDLE.
- plaintext  in  64  block input; sampled with start.
- key  in  80  cipher key; sampled with start.
- busy  out  1  high while a block is in flight (ROUND or FINAL).
- ready  out  1  high in IDLE; equals ~busy.
- done  out  1  one-cycle pulse when ciphertext becomes valid.
- ciphertext  out  64  result; holds its value until the next completion or reset.

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE; round counter=0; state and key registers=0; ciphertext=0; done=0; busy=0; ready=1.
- FSM states: IDLE, ROUND, FINAL.
  - IDLE→ROUND on start=1 at edge T0:
    - state_reg<=plaintext; key_reg<=key; rc<=1.
  - ROUND, one edge per round, rc=1..31:
    - state_reg<=PLayer(SLayer(state_reg ^ key_reg[79:16])).
    - key_reg<=key_update(key_reg, rc); rc<=rc+1.
    - Leave to FINAL on the edge where rc==31.
  - FINAL, one edge:
    - ciphertext<=state_reg ^ key_reg[79:16]; done<=1; →IDLE.
- Key update, PRESENT-80:
  - rotate key left by 61.
  - bits[79:76]<=SBOX(bits[79:76]).
  - bits[19:15]^=rc[4:0].
- SBOX (hex, input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Latency:
  - done is high during the cycle after edge T32, i.e. exactly 32 clocks after the accepting edge.
  - Throughput is 1 block per 33 clocks, since start can be accepted on the cycle done is high.
- start while busy: ignored; no queuing and no corruption of the in-flight block.
- start held high continuously: a new block is accepted each time the FSM is in IDLE, so back-to-back encryptions run.
- plaintext and key may change freely after the accepting edge.
- done:
  - Driven 0 on every edge except the FINAL edge, so it is a single-cycle pulse even if start is asserted in the same cycle.
- ciphertext: updated only on the FINAL edge; otherwise stable.
- Reset mid-operation: immediate abort to the reset values above; no done pulse; ciphertext cleared.
- Round counter never wraps: its range is 0..31, and it is reloaded to 1 on acceptance.

Decomposition:
- Shared package present_pkg:
  - width constants BLOCK_W=64, KEY_W=80, ROUNDS=31.
  - SBOX constant array and sbox4 function.
  - FSM state enum typedef (IDLE, ROUND, FINAL).
- Reuse the existing PLayer module unchanged, instantiated once.
- One natural sub-module: present80_key_update, combinational (key_in[79:0], rc[4:0] → key_out[79:0]). It is verified standalone against the first round keys.
- SLayer stays inline: 16 sbox4 calls in a generate loop.

Test Plan:
- pt=0000000000000000, key=0 → done after 32 clocks, ciphertext=5579C1387B228445; busy high for exactly 32 cycles.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF → ciphertext=E72C46C0F5945049.
- pt=FFFFFFFFFFFFFFFF, key=0 → A112FFC72F68417B. Then pt=FFFFFFFFFFFFFFFF, key=all-F, with start held high continuously → second result 3333DCD3213210D2 with done pulses 33 clocks apart.
- Pulse start with a different pt at rounds 5 and 20 of an in-flight block → first result unaffected, only one done pulse, ciphertext matches the original vector.
- Assert reset asynchronously mid-cycle at round 17 → outputs return to reset values before the next edge, no done pulse. A following start with pt=0, key=0 yields 5579C1387B228445.
- Hold start=0 for 100 cycles after a completion → done stays 0, ciphertext holds its last value, ready=1.
